ps2_keyboard_rx: RTL and testbench

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_keyboard_rx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered clock, frame FSM with timeout,
// raw keycode history and an E0/F0-aware event FIFO (first-word-fall-through).
module ps2_keyboard_rx #(
    parameter int CLK_HZ     = 100000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int HIST_BYTES = 4
) (
    input  logic                    CLK100MHZ,
    input  logic                    RST,
    input  logic                    PS2_CLK,
    input  logic                    PS2_DATA,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [7:0]              ev_code,
    output logic                    ev_ext,
    output logic                    ev_break,
    output logic [8*HIST_BYTES-1:0] keycode,
    output logic                    flag,
    output logic                    err_parity,
    output logic                    err_frame,
    output logic                    overflow
);

    localparam int TMO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int KW      = 8 * HIST_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ---- stage p0/p1: two-flop synchronisers (idle bus level is high)
    logic ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= PS2_CLK;
            ps2c_p1 <= ps2c_p0;
            ps2d_p0 <= PS2_DATA;
            ps2d_p1 <= ps2d_p0;
        end
    end

    // ---- glitch filter: filt_cnt counts consecutive samples that disagree with filt_clk
    logic             filt_clk;
    logic [FLT_W-1:0] filt_cnt;
    logic             flt_hit;
    logic             fall_evt;

    assign flt_hit  = (ps2c_p1 != filt_clk) && (filt_cnt == FLT_W'(FILTER_LEN - 1));
    assign fall_evt = flt_hit && filt_clk;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (ps2c_p1 == filt_clk) begin
            filt_cnt <= '0;
        end else if (flt_hit) begin
            filt_clk <= ps2c_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FLT_W'(1);
        end
    end

    // ---- frame FSM with inter-edge timeout and keycode history
    state_t           state;
    logic [2:0]       bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       shreg;
    logic             par_bit;

    always_ff @(posedge CLK100MHZ) begin
        if (fall_evt && state == S_DATA)   shreg   <= {ps2d_p1, shreg[7:1]};
        if (fall_evt && state == S_PARITY) par_bit <= ps2d_p1;
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            flag       <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            keycode    <= '0;
        end else begin
            flag       <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            if (state == S_IDLE || fall_evt) tmo_cnt <= '0;
            else                             tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state != S_IDLE && !fall_evt && tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                err_frame <= 1'b1;
                state     <= S_IDLE;
                bit_cnt   <= '0;
            end else if (fall_evt) begin
                case (state)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        if (!ps2d_p1) state     <= S_DATA;
                        else          err_frame <= 1'b1;
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: state <= S_STOP;
                    S_STOP: begin
                        state <= S_IDLE;
                        // a bad stop bit outranks a parity error
                        if (!ps2d_p1)                 err_frame  <= 1'b1;
                        else if (!(^{shreg, par_bit})) err_parity <= 1'b1;
                        else begin
                            flag    <= 1'b1;
                            keycode <= (keycode << 8) | KW'(shreg);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // ---- prefix decode: flag marks keycode[7:0] as a fresh good byte
    logic ext_pend, brk_pend;
    logic is_e0, is_f0, push;

    assign is_e0 = keycode[7:0] == 8'hE0;
    assign is_f0 = keycode[7:0] == 8'hF0;
    assign push  = flag && !is_e0 && !is_f0;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (flag) begin
            if (is_e0)      ext_pend <= 1'b1;
            else if (is_f0) brk_pend <= 1'b1;
            else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // ---- event FIFO; the extra pointer bit separates full from empty
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_valid = !empty;
    assign pop      = !empty && ev_ready;
    assign wr_en    = push && (!full || pop);
    assign {ev_code, ev_ext, ev_break} = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK100MHZ) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {keycode[7:0], ext_pend, brk_pend};
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)                 wr_ptr   <= wr_ptr + (AW+1)'(1);
            if (pop)                   rd_ptr   <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop)  overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus randomized frames against a queue-based model.
module tb_ps2_keyboard_rx;

    localparam int CLK_HZ     = 1000000;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT_US = 300;
    localparam int FIFO_DEPTH = 8;
    localparam int HIST_BYTES = 4;
    localparam int HP         = 16;
    localparam int TMO_CYC    = CLK_HZ / 1000000 * TIMEOUT_US;

    logic        CLK100MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [7:0]  ev_code;
    logic        ev_ext, ev_break;
    logic [31:0] keycode;
    logic        flag, err_parity, err_frame, overflow;

    ps2_keyboard_rx #(
        .CLK_HZ(CLK_HZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US),
        .FIFO_DEPTH(FIFO_DEPTH), .HIST_BYTES(HIST_BYTES)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .keycode(keycode), .flag(flag), .err_parity(err_parity),
        .err_frame(err_frame), .overflow(overflow)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_chk = 0, n_err = 0;
    int cnt_flag = 0, cnt_perr = 0, cnt_ferr = 0, n_pop = 0;
    int exp_flag = 0, exp_perr = 0, exp_ferr = 0;
    logic [9:0]  exp_q[$];
    logic [31:0] m_kc = '0;
    logic        m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
    bit          rdy_mode = 1'b0;
    logic        rdy_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        m_kc = {m_kc[23:0], b};
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({b, m_ext, m_brk});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    always @(negedge CLK100MHZ) begin
        if (!RST) begin
            if (flag)       cnt_flag++;
            if (err_parity) cnt_perr++;
            if (err_frame)  cnt_ferr++;
        end
    end

    // every pop must match the model queue head, in order
    always @(negedge CLK100MHZ) begin
        logic [31:0] want;
        if (!RST && ev_valid && ev_ready) begin
            n_pop++;
            want = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            chk("pop", 32'({ev_code, ev_ext, ev_break}), want);
        end
    end

    always @(posedge CLK100MHZ) begin
        #1;
        ev_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] fr;
        logic        par;
        par = (~^b) ^ bad_par;
        fr  = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = fr[i];
            if (glitch && i == 4) begin
                tick(4);
                PS2_CLK = 1'b0;
                tick(FILTER_LEN - 1);
                PS2_CLK = 1'b1;
                tick(HP - 4 - (FILTER_LEN - 1));
            end else begin
                tick(HP);
            end
            PS2_CLK = 1'b0;
            if (i == 10) begin
                if (bad_stop)     exp_ferr++;
                else if (bad_par) exp_perr++;
                else begin
                    exp_flag++;
                    model_byte(b);
                end
            end
            tick(HP);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        tick(HP);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_flag"}, 32'(cnt_flag), 32'(exp_flag));
        chk({tag, "_perr"}, 32'(cnt_perr), 32'(exp_perr));
        chk({tag, "_ferr"}, 32'(cnt_ferr), 32'(exp_ferr));
        chk({tag, "_kc"}, keycode, m_kc);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        tick(2);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_kc", keycode, 0);
        chk("rst_pulses", 32'({flag, err_parity, err_frame, overflow}), 0);
        exp_q.delete();
        m_kc = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        RST = 1'b0;
        tick(4);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        rdy_hold = 1'b1;
        while (ev_valid && t < 300) begin
            tick(1);
            t++;
        end
        rdy_hold = 1'b0;
        tick(3);
        chk({tag, "_empty"}, 32'(ev_valid), 0);
        chk({tag, "_model_left"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] b;
        tick(3);
        do_reset();

        // good 0x1C with consumer stalled
        send_frame(8'h1C, 0, 0, 0, 11);
        check_frame("s1");
        chk("s1_kc_lit", keycode, 32'h0000001C);
        chk("s1_head", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h1C, 1'b0, 1'b0}));
        drain("s1");

        // E0 F0 74 collapses into one extended break event
        do_reset();
        p0 = n_pop;
        send_frame(8'hE0, 0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 0, 11);
        send_frame(8'h74, 0, 0, 0, 11);
        check_frame("s2");
        chk("s2_kc_lit", keycode, 32'h00E0F074);
        chk("s2_head", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h74, 1'b1, 1'b1}));
        drain("s2");
        chk("s2_npop", 32'(n_pop - p0), 1);

        // parity error leaves history and FIFO alone
        send_frame(8'h1C, 1, 0, 0, 11);
        check_frame("s3");
        chk("s3_valid", 32'(ev_valid), 0);

        // nine makes into an eight-deep stalled FIFO
        do_reset();
        p0 = n_pop;
        for (int c = 8'h15; c <= 8'h1D; c++) send_frame(8'(c), 0, 0, 0, 11);
        check_frame("s4");
        chk("s4_ovf_lit", 32'(overflow), 1);
        drain("s4");
        chk("s4_npop", 32'(n_pop - p0), 8);
        chk("s4_ovf_sticky", 32'(overflow), 1);

        // timeout after start + 5 data bits, then a normal frame
        do_reset();
        send_frame(8'hA5, 0, 0, 0, 6);
        tick(TMO_CYC + 100);
        exp_ferr++;
        check_frame("s5_tmo");
        send_frame(8'h1C, 0, 0, 0, 11);
        check_frame("s5");
        chk("s5_head", 32'({ev_valid, ev_code}), 32'({1'b1, 8'h1C}));
        drain("s5");

        // short clock glitches while idle and mid-frame are ignored
        PS2_CLK = 1'b0;
        tick(FILTER_LEN - 1);
        PS2_CLK = 1'b1;
        tick(HP);
        send_frame(8'h3A, 0, 0, 1, 11);
        check_frame("s6_glitch");
        drain("s6g");

        // reset mid-frame aborts it; next frame is clean
        send_frame(8'h55, 0, 0, 0, 4);
        do_reset();
        send_frame(8'h29, 0, 0, 0, 11);
        check_frame("s6");
        chk("s6_head", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h29, 1'b0, 1'b0}));
        drain("s6");

        // randomized traffic with a randomly stalling consumer
        rdy_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r, e;
            r = $urandom_range(0, 9);
            if (r < 2) send_frame(8'hE0, 0, 0, 0, 11);
            if (r == 2 || r == 3) send_frame(8'hF0, 0, 0, 0, 11);
            b = 8'($urandom_range(0, 255));
            e = $urandom_range(0, 9);
            send_frame(b, e == 0, e == 1, $urandom_range(0, 3) == 0, 11);
            check_frame("rnd");
        end
        rdy_mode = 1'b0;
        tick(2);
        drain("rnd");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
